// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and framing constants for the UART transmit scheduler
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_STOP_BITS = 1;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick, searching upward from last+1
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_last,
    output logic               o_any,
    output logic [ID_W-1:0]    o_win
);

    // Scan farthest-first so the nearest asserted requester after i_last is the final assignment.
    always_comb begin
        o_any = 1'b0;
        o_win = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            int idx;
            idx = (int'(i_last) + k) % NUM_REQ;
            if (i_req[idx]) begin
                o_any = 1'b1;
                o_win = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin shared 8N1 transmitter, bit boundaries aligned to txclk_en
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk_50m,
    input  logic                 rst_n,
    input  logic                 txclk_en,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx,
    output logic                 busy,
    output logic [ID_W-1:0]      grant_id
);

    tx_state_t    r_state;
    logic         r_tx;
    logic         r_busy;
    logic [NUM_REQ-1:0] r_ready;
    logic [ID_W-1:0]    r_gid;
    logic [ID_W-1:0]    r_last;
    logic [7:0]   r_shift;
    logic [2:0]   r_bit_idx;

    tx_state_t    w_state;
    logic         w_tx;
    logic         w_busy;
    logic [NUM_REQ-1:0] w_ready;
    logic [ID_W-1:0]    w_gid;
    logic [ID_W-1:0]    w_last;
    logic [7:0]   w_shift;
    logic [2:0]   w_bit_idx;
    logic         w_grant;
    logic         w_any;
    logic [ID_W-1:0]    w_win;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .i_req  (req_valid),
        .i_last (r_last),
        .o_any  (w_any),
        .o_win  (w_win)
    );

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_ready   <= '0;
            r_gid     <= '0;
            r_last    <= ID_W'(NUM_REQ - 1);
            r_shift   <= '0;
            r_bit_idx <= '0;
        end else begin
            r_state   <= w_state;
            r_tx      <= w_tx;
            r_busy    <= w_busy;
            r_ready   <= w_ready;
            r_gid     <= w_gid;
            r_last    <= w_last;
            r_shift   <= w_shift;
            r_bit_idx <= w_bit_idx;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_tx      = r_tx;
        w_busy    = r_busy;
        w_ready   = '0;
        w_gid     = r_gid;
        w_last    = r_last;
        w_shift   = r_shift;
        w_bit_idx = r_bit_idx;
        w_grant   = 1'b0;

        case (r_state)
            IDLE: begin
                w_tx   = 1'b1;
                w_busy = 1'b0;
                if (w_any) begin
                    w_grant = 1'b1;
                    w_busy  = 1'b1;
                    w_state = ALIGN;
                end
            end
            ALIGN: begin
                if (txclk_en) begin
                    w_tx    = 1'b0;
                    w_state = START;
                end
            end
            START: begin
                if (txclk_en) begin
                    w_tx      = r_shift[0];
                    w_shift   = r_shift >> 1;
                    w_bit_idx = '0;
                    w_state   = DATA;
                end
            end
            DATA: begin
                if (txclk_en) begin
                    if (r_bit_idx < 3'(UART_DATA_BITS - 1)) begin
                        w_bit_idx = r_bit_idx + 3'd1;
                        w_tx      = r_shift[0];
                        w_shift   = r_shift >> 1;
                    end else begin
                        w_tx    = 1'b1;
                        w_state = STOP;
                    end
                end
            end
            STOP: begin
                // A waiting requester starts its start bit on this same tick: one stop bit only.
                if (txclk_en) begin
                    if (w_any) begin
                        w_grant = 1'b1;
                        w_tx    = 1'b0;
                        w_state = START;
                    end else begin
                        w_busy  = 1'b0;
                        w_state = IDLE;
                    end
                end
            end
            default: begin
                w_tx    = 1'b1;
                w_busy  = 1'b0;
                w_state = IDLE;
            end
        endcase

        if (w_grant) begin
            w_ready = NUM_REQ'(1) << w_win;
            w_shift = req_data[int'(w_win)*8 +: 8];
            w_gid   = w_win;
            w_last  = w_win;
        end
    end

    assign tx        = r_tx;
    assign busy      = r_busy;
    assign req_ready = r_ready;
    assign grant_id  = r_gid;

endmodule
